sample_sdiv_seq: RTL
====================

Name: sample_sdiv_seq

Overview:
- Sequential signed integer divider. It is the inverse-operation companion to the pipelined signed multiplier cores in the HLS-generated sample datapath.
- It takes a W-bit signed dividend and divisor and produces a W-bit quotient and remainder using truncating (C-style) semantics.
- Implementation: iterative restoring division, one quotient bit per enabled clock, with a start/done handshake for the scheduling FSM.
- Output truncation follows the datapath rule: results wrap to W bits.

Parameters:
- ID, 32'd1, instance identifier; no functional effect.
- W, 13, operand/result width in bits. Legal range 2..32.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when low, all state, counters and outputs hold.
- start  input  1  request; sampled only in IDLE with ce=1.
- din0  input  W  signed dividend; sampled on the accepting edge.
- din1  input  W  signed divisor; sampled on the accepting edge.
- busy  output  1  high in every state other than IDLE.
- done  output  1  high for exactly one enabled cycle (DONE state).
- dout  output  W  signed quotient; registered, holds until the next done.
- rem  output  W  signed remainder; registered, holds until the next done.
- div_by_zero  output  1  set with done when din1==0; holds with dout.

Behaviour:
- Reset (synchronous, reset=1 at edge, overrides ce):
  - state=IDLE.
  - dout=0, rem=0, done=0, busy=0, div_by_zero=0.
  - Internal registers cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, FIX, DONE. Every transition requires ce=1.
- Accept edge E0: IDLE with start=1.
  - Capture sign_q = sign(din0) XOR sign(din1) and sign_r = sign(din0).
  - Capture magnitudes |din0| and |din1| as W-bit unsigned. |-2^(W-1)| = 2^(W-1) fits in W unsigned bits.
  - Clear partial remainder (W+1 bits); iteration counter = W-1.
  - Go to CALC.
- CALC, edges E1..EW:
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract |divisor|. If non-negative, keep the difference and set q bit = 1; else restore and set q bit = 0.
  - Decrement the counter. At counter=0 go to FIX.
- FIX, edge E(W+1):
  - dout = sign_q ? -q : q, truncated to W bits.
  - rem = sign_r ? -r : r.
  - Go to DONE.
- DONE, edge E(W+2): done=1 during this state; go to IDLE.
- Latency: done is visible in the cycle after edge E(W+1). For W=13 that is 14 enabled edges after acceptance. Minimum start-to-start spacing is W+3 enabled cycles.
- start in CALC, FIX or DONE is ignored; there is no queuing.
- ce=0 in any state freezes the state, counter and outputs. done stays high if frozen in DONE. The latency counts enabled edges only.
- Overflow: -2^(W-1) / -1 wraps to -2^(W-1) with rem=0. div_by_zero stays 0.
- Divide by zero (din1==0):
  - The operation runs full latency.
  - dout = din0>=0 ? 2^(W-1)-1 : -2^(W-1).
  - rem = din0; div_by_zero=1.
- din0 and din1 may change freely after E0.

Optional Feature:
- Macro: SAMPLE_SDIV_EARLY_EXIT_EN.
- Defined: at E0, if din1==0 or |din0| < |din1|, go IDLE->FIX directly.
  - The FIX results are then: zero divisor uses the divide-by-zero rule; otherwise dout=0, rem=din0.
  - done is visible after E1 (2-edge latency).
  - All other operands use full latency.
- Undefined: latency is always W+1 enabled edges to done; no comparator logic is present.

Test Plan:
- Reset held 3 cycles during CALC -> busy=0, done=0, dout=0, rem=0 next cycle; no done follows.
- 100/7, W=13, ce=1 -> done after 14 edges, dout=14, rem=2, div_by_zero=0. Then -100/7 -> dout=-14, rem=-2; 100/-7 -> dout=-14, rem=2.
- -4096/-1 -> dout=-4096 (0x1000), rem=0, div_by_zero=0. 4095/1 -> dout=4095, rem=0.
- 5/0 -> dout=4095, rem=5, div_by_zero=1. -5/0 -> dout=-4096, rem=-5. Same latency unless the macro is defined; with the macro, done follows 2 edges after start.
- Start pulsed every cycle during an operation, ce toggling 1010 -> only the first request is processed; done occurs after 14 enabled edges and stays high while ce=0 in DONE.
- Random 1000 pairs (divisor≠0) vs reference model q=trunc(a/b), r=a-q*b wrapped to 13 bits -> exact match. Back-to-back throughput of 16 cycles is verified.

Source files
------------

// File: rtl/sample_sdiv_seq.sv
// Sequential signed divider (restoring, one quotient bit per enabled clock).
// Latency: W+1 enabled edges from accept to done (2 with SAMPLE_SDIV_EARLY_EXIT_EN on trivial operands).
// Backpressure: none; start is ignored while busy, ce=0 freezes all state and outputs.
//
// Ports:
//   clk, reset (sync, active-high, overrides ce), ce (clock enable)
//   start      : request, accepted only in IDLE with ce=1
//   din0, din1 : signed dividend / divisor, sampled on the accepting edge
//   busy       : high in every state other than IDLE
//   done       : high for the single DONE state (stays high while frozen there)
//   dout, rem  : signed quotient / remainder, truncating semantics, wrap to W bits
//   div_by_zero: set alongside the results when din1 was zero
//
// Optional macro SAMPLE_SDIV_EARLY_EXIT_EN: skip the iterations when the
// divisor is zero or |din0| < |din1| (quotient is known to be zero).
module sample_sdiv_seq #(
  parameter logic [31:0] ID = 32'd1,
  parameter int          W  = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         start,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dout,
  output logic [W-1:0] rem,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dvd_q, dvd_d;    // dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]  dvs_q, dvs_d;    // |divisor|
  logic [W-1:0]  prem_q, prem_d;  // partial remainder
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          zero_q, zero_d;
  logic          dbz_q, dbz_d;

  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    shifted, diff;
  logic          early;

  // Instance ID has no functional effect.
  logic unused_id;
  assign unused_id = ^ID;

  // |x| of the most negative value wraps to 2^(W-1), which is exact as unsigned.
  assign a_mag = din0[W-1] ? -din0 : din0;
  assign b_mag = din1[W-1] ? -din1 : din1;

`ifdef SAMPLE_SDIV_EARLY_EXIT_EN
  assign early = (din1 == '0) || (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // Partial remainder stays below 2^(W-1) before each shift, so W+1 bits hold
  // the trial difference and its top bit is a valid sign. With a zero divisor
  // every trial succeeds and the partial remainder ends up equal to |din0|.
  assign shifted = {prem_q, dvd_q[W-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          qneg_d = din0[W-1] ^ din1[W-1];
          rneg_d = din0[W-1];
          zero_d = (din1 == '0);
          dvs_d  = b_mag;
          cnt_d  = CW'(W - 1);
          if (early) begin
            // Quotient is zero and the remainder is the whole dividend.
            dvd_d   = '0;
            prem_d  = a_mag;
            state_d = FIX;
          end else begin
            dvd_d   = a_mag;
            prem_d  = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[W]) prem_d = diff[W-1:0];
        else          prem_d = shifted[W-1:0];
        dvd_d = {dvd_q[W-2:0], ~diff[W]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (zero_q)      dout_d = rneg_q ? MINV : MAXV;
        else if (qneg_q) dout_d = -dvd_q;
        else             dout_d = dvd_q;
        rem_d   = rneg_q ? -prem_q : prem_q;
        dbz_d   = zero_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule
